// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (CPU, loader) arbiter for a single-port
// synchronous memory with one cycle of read latency.
// Every access takes an ACC cycle with mem_* driven, followed by an ACK
// cycle in which the requester's ack pulses and rdata carries mem_rdata.
// Handshake: a requester holds x_req (and its addr/we/wdata) until it sees
// x_ack high. The command is captured when the grant is taken. An access
// that has been granted always completes, even if x_req drops in ACC.
// Optional feature: define ARB_ROUND_ROBIN_EN so that simultaneous
// requests alternate between the two requesters. By default the loader
// has fixed priority. ldr_lock overrides arbitration in both builds.
module mem_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       ldr_req,
    input  logic       ldr_we,
    input  logic [7:0] ldr_addr,
    input  logic [7:0] ldr_wdata,
    input  logic       ldr_lock,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    input  logic [7:0] mem_rdata,
    output logic       cpu_ack,
    output logic       ldr_ack,
    output logic [7:0] rdata,
    output logic       cpu_hold,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CPU_ACC = 3'd1,
        CPU_ACK = 3'd2,
        LDR_ACC = 3'd3,
        LDR_ACK = 3'd4
    } state_t;

    state_t state;
    logic   pick_cpu;
    logic   pick_ldr;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when the loader holds the most recent grant
    logic   last_ldr;
`endif

    // Grant decision. A new grant is only taken from IDLE or an ACK cycle,
    // and an ACK cycle never re-grants the requester it is acknowledging.
    always_comb begin
        pick_cpu = 1'b0;
        pick_ldr = 1'b0;
        case (state)
            IDLE: begin
                if (ldr_lock) begin
                    pick_ldr = ldr_req;
                end else if (cpu_req && ldr_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    pick_cpu = last_ldr;
                    pick_ldr = !last_ldr;
`else
                    pick_ldr = 1'b1;
`endif
                end else begin
                    pick_cpu = cpu_req;
                    pick_ldr = ldr_req;
                end
            end
            CPU_ACK: pick_ldr = ldr_req;
            LDR_ACK: pick_cpu = cpu_req && !ldr_lock;
            default: begin
                pick_cpu = 1'b0;
                pick_ldr = 1'b0;
            end
        endcase
    end

    // Main FSM with registered memory command and ack pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_addr  <= 8'h00;
            mem_wdata <= 8'h00;
            mem_we    <= 1'b0;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            case (state)
                CPU_ACC: begin
                    state   <= CPU_ACK;
                    cpu_ack <= 1'b1;
                end
                LDR_ACC: begin
                    state   <= LDR_ACK;
                    ldr_ack <= 1'b1;
                end
                default: begin
                    if (pick_ldr) begin
                        state     <= LDR_ACC;
                        mem_addr  <= ldr_addr;
                        mem_wdata <= ldr_wdata;
                        mem_we    <= ldr_we;
                    end else if (pick_cpu) begin
                        state     <= CPU_ACC;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        mem_we    <= cpu_we;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember who was granted last; starts at loader so the first tie goes to the CPU
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_ldr <= 1'b1;
        end else if (pick_ldr) begin
            last_ldr <= 1'b1;
        end else if (pick_cpu) begin
            last_ldr <= 1'b0;
        end
    end
`endif

    // Read data only arrives one cycle after ACC, so it is passed through in ACK
    assign rdata = ((state == CPU_ACK) || (state == LDR_ACK)) ? mem_rdata : 8'h00;

    // CPU must freeze while it waits for a grant or while the loader holds the lock
    assign cpu_hold = rst & ((cpu_req & (state != CPU_ACC) & (state != CPU_ACK)) | ldr_lock);

    assign state_dbg = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbiter and a shadow memory.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_addr = 8'h00;
  logic [7:0] cpu_wdata = 8'h00;
  logic       ldr_req = 1'b0;
  logic       ldr_we = 1'b0;
  logic [7:0] ldr_addr = 8'h00;
  logic [7:0] ldr_wdata = 8'h00;
  logic       ldr_lock = 1'b0;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata = 8'h00;
  logic       cpu_ack;
  logic       ldr_ack;
  logic [7:0] rdata;
  logic       cpu_hold;
  logic [2:0] state_dbg;

  int checks = 0;
  int errs = 0;

  // clock / reset block
  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_lock(ldr_lock),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .cpu_ack(cpu_ack), .ldr_ack(ldr_ack), .rdata(rdata), .cpu_hold(cpu_hold),
    .state_dbg(state_dbg)
  );

  // physical memory attached to the DUT: synchronous write, read-old-data
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // transaction-level reference: who owns the bus and how far along the access is
  logic [7:0] ref_mem [256];
  int         m_cur = 0;          // 0 none, 1 cpu, 2 loader
  int         m_age = 0;          // 1 = address cycle, 2 = acknowledge cycle
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_wdata = 8'h00;
  logic       m_we = 1'b0;
  logic [7:0] m_rd = 8'h00;
  bit         m_last_ldr = 1'b1;

  always @(posedge clk or negedge rst) begin
    bit c_ok;
    bit l_ok;
    int win;
    if (!rst) begin
      m_cur = 0; m_age = 0; m_addr = 8'h00; m_wdata = 8'h00; m_we = 1'b0;
      m_last_ldr = 1'b1;
    end else if (m_cur != 0 && m_age == 1) begin
      m_rd = ref_mem[m_addr];
      if (m_we) ref_mem[m_addr] = m_wdata;
      m_age = 2;
    end else begin
      c_ok = cpu_req && !ldr_lock && (m_cur != 1);
      l_ok = ldr_req && (m_cur != 2);
      if (c_ok && l_ok) begin
`ifdef ARB_ROUND_ROBIN_EN
        win = m_last_ldr ? 1 : 2;
`else
        win = 2;
`endif
      end else if (l_ok) win = 2;
      else if (c_ok) win = 1;
      else win = 0;
      m_cur = win;
      m_age = (win == 0) ? 0 : 1;
      if (win == 1) begin
        m_addr = cpu_addr; m_wdata = cpu_wdata; m_we = cpu_we; m_last_ldr = 1'b0;
      end else if (win == 2) begin
        m_addr = ldr_addr; m_wdata = ldr_wdata; m_we = ldr_we; m_last_ldr = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare process: every cycle, away from the rising edge
  always @(negedge clk) begin
    chk("mem_we", {31'd0, mem_we}, {31'd0, (m_cur != 0 && m_age == 1) ? m_we : 1'b0});
    chk("cpu_ack", {31'd0, cpu_ack}, (m_cur == 1 && m_age == 2) ? 32'd1 : 32'd0);
    chk("ldr_ack", {31'd0, ldr_ack}, (m_cur == 2 && m_age == 2) ? 32'd1 : 32'd0);
    chk("rdata", {24'd0, rdata}, {24'd0, (m_cur != 0 && m_age == 2) ? m_rd : 8'h00});
    chk("mem_addr", {24'd0, mem_addr}, {24'd0, m_addr});
    chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, m_wdata});
    chk("cpu_hold", {31'd0, cpu_hold},
        {31'd0, rst && ((cpu_req && m_cur != 1) || ldr_lock)});
    chk("ack_excl", {31'd0, cpu_ack & ldr_ack}, 32'd0);
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic cpu_issue(input logic we, input logic [7:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic ldr_issue(input logic we, input logic [7:0] a, input logic [7:0] d);
    ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = d;
  endtask

  initial begin
    bit got;
    int diffs;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 8'h5A; ref_mem[8'h10] = 8'h5A;
    mem[8'h40] = 8'h11; ref_mem[8'h40] = 8'h11;

    // reset: outputs forced low even with cpu_req and ldr_lock raised
    cpu_req = 1'b1; ldr_lock = 1'b1;
    step(); step();
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    cpu_req = 1'b0; ldr_lock = 1'b0;
    rst = 1'b1;
    step();

    // simultaneous requests
    ldr_issue(1'b0, 8'h21, 8'h00);
    cpu_issue(1'b0, 8'h22, 8'h00);
`ifdef ARB_ROUND_ROBIN_EN
    step();
    chk("tie_cpu_first_addr", {24'd0, mem_addr}, 32'h22);
    chk("tie_cpu_first_hold", {31'd0, cpu_hold}, 32'd0);
    step();
    chk("tie_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    cpu_req = 1'b0;
    step();
    chk("tie_ldr_second_addr", {24'd0, mem_addr}, 32'h21);
    step();
    chk("tie_ldr_ack", {31'd0, ldr_ack}, 32'd1);
    ldr_req = 1'b0;
    step();
`else
    step();
    chk("tie_ldr_first_addr", {24'd0, mem_addr}, 32'h21);
    chk("tie_hold_ldr_acc", {31'd0, cpu_hold}, 32'd1);
    step();
    chk("tie_ldr_ack", {31'd0, ldr_ack}, 32'd1);
    chk("tie_hold_ldr_ack", {31'd0, cpu_hold}, 32'd1);
    ldr_req = 1'b0;
    step();
    chk("tie_cpu_second_addr", {24'd0, mem_addr}, 32'h22);
    chk("tie_hold_cpu_acc", {31'd0, cpu_hold}, 32'd0);
    step();
    chk("tie_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    cpu_req = 1'b0;
    step();
`endif

    // CPU read alone
    cpu_issue(1'b0, 8'h10, 8'h00);
    step();
    chk("rd_acc_addr", {24'd0, mem_addr}, 32'h10);
    chk("rd_acc_noack", {31'd0, cpu_ack}, 32'd0);
    step();
    chk("rd_ack", {31'd0, cpu_ack}, 32'd1);
    chk("rd_data", {24'd0, rdata}, 32'h5A);
    cpu_req = 1'b0;
    step();
    chk("rd_ack_once", {31'd0, cpu_ack}, 32'd0);

    // loader write then CPU readback
    ldr_issue(1'b1, 8'h03, 8'hA7);
    step();
    chk("wr_we", {31'd0, mem_we}, 32'd1);
    chk("wr_addr", {24'd0, mem_addr}, 32'h03);
    chk("wr_data", {24'd0, mem_wdata}, 32'hA7);
    step();
    chk("wr_we_one_cycle", {31'd0, mem_we}, 32'd0);
    chk("wr_ack", {31'd0, ldr_ack}, 32'd1);
    ldr_req = 1'b0;
    step();
    cpu_issue(1'b0, 8'h03, 8'h00);
    step(); step();
    chk("readback", {24'd0, rdata}, 32'hA7);
    cpu_req = 1'b0;
    step();

    // CPU request dropped during its address cycle
    cpu_issue(1'b0, 8'h10, 8'h00);
    step();
    chk("drop_acc_addr", {24'd0, mem_addr}, 32'h10);
    cpu_req = 1'b0;
    step();
    chk("drop_ack", {31'd0, cpu_ack}, 32'd1);
    chk("drop_rdata", {24'd0, rdata}, 32'h5A);
    step();
    chk("drop_ack_once", {31'd0, cpu_ack}, 32'd0);
    step();
    chk("drop_idle_we", {31'd0, mem_we}, 32'd0);
    chk("drop_idle_ack", {31'd0, cpu_ack}, 32'd0);

    // loader lock starves the CPU
    ldr_lock = 1'b1;
    cpu_issue(1'b0, 8'h10, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("lock_no_ack", {31'd0, cpu_ack}, 32'd0);
      chk("lock_hold", {31'd0, cpu_hold}, 32'd1);
    end
    ldr_lock = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (cpu_ack) got = 1'b1;
    end
    chk("unlock_ack_within_2", {31'd0, got}, 32'd1);
    cpu_req = 1'b0;
    step();

    // reset during a loader write
    ldr_issue(1'b1, 8'h40, 8'hEE);
    step();
    chk("abort_we_before", {31'd0, mem_we}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("abort_we_drop", {31'd0, mem_we}, 32'd0);
    chk("abort_ldr_ack", {31'd0, ldr_ack}, 32'd0);
    chk("abort_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("abort_rdata", {24'd0, rdata}, 32'd0);
    chk("abort_addr", {24'd0, mem_addr}, 32'd0);
    chk("abort_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("abort_hold", {31'd0, cpu_hold}, 32'd0);
    ldr_req = 1'b0;
    step(); step();
    chk("abort_mem_unchanged", {24'd0, mem[8'h40]}, 32'h11);
    rst = 1'b1;
    step();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if (cpu_req && cpu_ack) cpu_req = 1'b0;
      if (ldr_req && ldr_ack) ldr_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 2) == 0)
        cpu_issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
      if (!ldr_req && $urandom_range(0, 2) == 0)
        ldr_issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
      if ($urandom_range(0, 19) == 0) ldr_lock = !ldr_lock;
      step();
    end
    cpu_req = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0;
    for (int i = 0; i < 4; i++) step();

    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image", diffs, 32'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: cpu_req  in  1  CPU access request, held until cpu_ack; cpu_we  in  1  CPU write; cpu_addr  in  8; cpu_wdata  in  8.
REQ-004 SHALL have ports: ldr_req  in  1  loader access request, held until ldr_ack; ldr_we  in  1; ldr_addr  in  8; ldr_wdata  in  8; ldr_lock  in  1  keep grant with loader.
REQ-005 SHALL have ports: mem_addr  out  8; mem_wdata  out  8; mem_we  out  1  (memory: synchronous write, 1-cycle read latency); mem_rdata  in  8.
REQ-006 SHALL have ports: cpu_ack  out  1; ldr_ack  out  1; rdata  out  8  (valid with ack); cpu_hold  out  1  (freezes CPU state counter).

Function
REQ-007 SHALL implement FSM states IDLE, CPU_ACC, CPU_ACK, LDR_ACC, LDR_ACK.
REQ-008 SHALL, from IDLE, go to CPU_ACC or LDR_ACC when a request is pending, per arbitration rule (REQ-015/REQ-021); otherwise stay in IDLE.
REQ-009 SHALL register requester addr/we/wdata on entry to x_ACC and drive them on mem_* throughout x_ACC; mem_we = registered we in x_ACC only, 0 in every other state.
REQ-010 SHALL go unconditionally from x_ACC to x_ACK; in x_ACK pulse x_ack=1 for exactly one cycle and drive rdata = mem_rdata.
REQ-011 SHALL give latency: req sampled high in IDLE at edge N -> ACC cycle N+1 -> ack cycle N+2; 3 cycles per access minimum.
REQ-012 SHALL, from x_ACK, move directly to the next ACC state if a request other than the one just acked is pending (no IDLE bubble); else IDLE; the just-acked requester is not re-granted from its own ACK cycle.
REQ-013 SHALL complete an access already in x_ACC even if x_req drops (write still performed, ack still pulsed).
REQ-014 SHALL hold mem_addr, mem_wdata at last value and rdata at 0 outside ACC/ACK.
REQ-015 SHALL, with both requests pending and the macro undefined, grant loader.
REQ-016 SHALL, while ldr_lock=1, grant only the loader; CPU requests wait, even if loader is idle.
REQ-017 SHALL assert cpu_hold whenever cpu_req=1 and neither CPU_ACC nor CPU_ACK is current, or ldr_lock=1.
REQ-018 SHALL never assert cpu_ack and ldr_ack in the same cycle, nor mem_we outside an ACC state.

Reset
REQ-019 SHALL, on rst=0, immediately (asynchronously) enter IDLE and force mem_we=0, cpu_ack=0, ldr_ack=0, rdata=0, mem_addr=0, mem_wdata=0, cpu_hold=0; an in-flight access is abandoned without a write.
REQ-020 SHALL resume arbitration on the first rising clk edge after rst returns high.

Configuration
REQ-021 SHALL, when ARB_ROUND_ROBIN_EN is defined, resolve simultaneous requests round-robin: grant the requester not granted last; last-granted register resets to loader (first tie goes to CPU); ldr_lock still overrides.
REQ-022 SHALL, when ARB_ROUND_ROBIN_EN is undefined, use fixed loader priority and contain no last-granted register.

Verification
REQ-023 SHALL cover: CPU read alone, cpu_addr=8'h10, memory holds 8'h5A -> mem_addr=8'h10 in ACC, cpu_ack one cycle two edges after request, rdata=8'h5A.
REQ-024 SHALL cover: loader write ldr_addr=8'h03, ldr_wdata=8'hA7 -> mem_we=1 for exactly one cycle at 8'h03; readback by CPU returns 8'hA7.
REQ-025 SHALL cover: both requests raised same edge, macro undefined -> loader ACC/ACK then CPU ACC/ACK back-to-back, cpu_hold=1 until CPU_ACC; macro defined -> CPU first.
REQ-026 SHALL cover: ldr_lock=1 with cpu_req held for 10 cycles and no ldr_req -> no cpu_ack, cpu_hold=1; release lock -> cpu_ack within 2 cycles.
REQ-027 SHALL cover: rst asserted during LDR_ACC with ldr_we=1 -> mem_we drops same cycle, target location unchanged, all outputs 0.
REQ-028 SHALL cover: cpu_req dropped during CPU_ACC -> cpu_ack still pulses once, FSM returns to IDLE.
